fastinput_rate_meter: RTL and testbench
=======================================

// Module: fastinput_rate_meter
// PURPOSE
//  Downstream consumer of the 4-channel fast-input edge counters. Samples the four free-running
//  32-bit counts at a fixed gate interval and computes the per-channel edge count per window
//  (delta, modulo 2^CNT_W). Presents each window's result on a valid/ready interface to the
//  register/readout stage.
// PARAMETERS
//  CNT_W        32          width of incoming counters and of delta outputs
//  GATE_CYCLES  50000000    gate window length in clk cycles (>=4); 1 s at 50 MHz
//  ID_W         16          width of window sequence number
// PORTS
//  clk          in   1      system clock
//  rst          in   1      reset, asynchronous, active-low
//  enable       in   1      1 = measure; 0 = stop and return to IDLE
//  channel0..3  in   CNT_W  free-running edge counts from the fast-input counter stage
//  rate_ready   in   1      consumer accepts result when rate_valid & rate_ready
//  clr_overrun  in   1      synchronous clear of overrun flag
//  rate_valid   out  1      rate0..3 / window_id hold a valid unaccepted result
//  rate0..3     out  CNT_W  edges counted in the last completed window, per channel
//  window_id    out  ID_W   sequence number of the presented window; wraps at 2^ID_W
//  overrun      out  1      sticky: an unaccepted result was overwritten
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; gate counter, baseline and snapshot registers 0.
//  FSM states:
//   IDLE   enable=1 -> PRIME.
//   PRIME  one cycle: baseline[i] <= channel_i, gate_cnt <= 0 -> RUN.
//   RUN    gate_cnt increments each cycle. At gate_cnt==GATE_CYCLES-1: snap[i] <= channel_i,
//          gate_cnt <= 0, cap_pend <= 1. Windows are exactly GATE_CYCLES cycles back-to-back.
//   enable=0 in any state -> IDLE next cycle; pending cap_pend discarded, presented result
//   kept until accepted.
//  Capture stage (cycle after the snap edge, cap_pend=1):
//   delta[i] = snap[i] - baseline[i], CNT_W-bit unsigned subtract, modulo wrap.
//   Example: 0xFFFF_FFFE -> 0x0000_0003 gives 5.
//   rate_i <= delta[i]; baseline[i] <= snap[i]; window_id <= window_id+1; rate_valid <= 1.
//   Latency: rate_valid rises 2 clk edges after the terminal-count cycle.
//  Handshake:
//   - Result is stable while rate_valid=1 and rate_ready=0.
//   - Acceptance with no new load in the same cycle -> rate_valid <= 0.
//  Simultaneous events:
//   - New load while rate_valid=1 & rate_ready=0: overwrite with fresh result, overrun <= 1.
//   - New load in the same cycle as acceptance: load, rate_valid stays 1, no overrun.
//   - clr_overrun coincident with a new overrun: set wins.
//  Windows: first window after PRIME is the first result. window_id of the first result after
//   reset is 1; it is not cleared by enable toggling.
//  Reset mid-window: asynchronous clear of all state; no partial result is emitted.
// STRUCTURE
//  Shared include fastinput_defs.vh: CNT_W default, FSM state encodings (IDLE/PRIME/RUN),
//  channel count 4.
//  Sub-module fastinput_delta_ch, instantiated 4x: baseline/snap registers + modular subtract,
//  with prime/snap/cap strobes from the top FSM. Top holds FSM, gate counter, output regs,
//  handshake and overrun logic.
// TESTING (GATE_CYCLES=10 in bench)
//  1 Ramp ch0 +1/cycle, ch1 +2, ch2 static, ch3 +1 every 5 cycles; ready=1.
//    -> rate = 10,20,0,2 per window; valid pulses every 10 cycles; window_id 1,2,3...
//  2 ch0 baseline 0xFFFFFFFA, +1/cycle across a window.
//    -> rate0 = 10 (wrap-correct), no glitch.
//  3 Hold ready=0 across two windows.
//    -> second result overwrites first, overrun=1, window_id skips by 2 on accept.
//    -> clr_overrun returns it to 0.
//  4 Assert ready in the same cycle as a new load.
//    -> valid stays 1, new data presented, overrun stays 0.
//  5 Drop enable mid-window with result pending.
//    -> FSM IDLE, pending result kept until accepted, no further loads.
//    -> re-enable: PRIME, then the first result after a full GATE_CYCLES window.
//  6 Pulse rst low mid-window with valid=1.
//    -> all outputs 0 immediately (async); after release, no result until enable plus a full window.

Source files
------------

// File: rtl/fastinput_rate_meter_pkg.sv
// Shared definitions for the fast-input rate meter.
//   NUM_CH    : number of counter channels handled by the meter
//   CNT_W_DEF : default counter / delta width
//   state_e   : gate sequencer states (IDLE -> PRIME -> RUN)
package fastinput_rate_meter_pkg;

    localparam int NUM_CH    = 4;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/fastinput_rate_meter_delta_ch.sv
// One channel of the rate meter: keeps the count sampled at the start of the
// current window (baseline) and the count sampled at its end (snap), and
// presents their modular difference.
//   clk, rst  : clock, asynchronous active-low reset
//   prime     : load baseline from the live count (start of first window)
//   snap      : load snap from the live count (end of a window)
//   cap       : result consumed; snap becomes the next window's baseline
//   channel   : live free-running count
//   delta     : snap - baseline, modulo 2^CNT_W
module fastinput_rate_meter_delta_ch
    import fastinput_rate_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prime,
    input  logic             snap,
    input  logic             cap,
    input  logic [CNT_W-1:0] channel,
    output logic [CNT_W-1:0] delta
);

    logic [CNT_W-1:0] baseline_q, baseline_d;
    logic [CNT_W-1:0] snap_q, snap_d;

    always_comb begin
        baseline_d = baseline_q;
        snap_d     = snap_q;
        if (prime) begin
            baseline_d = channel;
        end else if (cap) begin
            baseline_d = snap_q;
        end
        if (snap) begin
            snap_d = channel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baseline_q <= '0;
            snap_q     <= '0;
        end else begin
            baseline_q <= baseline_d;
            snap_q     <= snap_d;
        end
    end

    // Unsigned subtract wraps naturally, so a counter rollover inside the
    // window still yields the true edge count.
    assign delta = snap_q - baseline_q;

endmodule

// File: rtl/fastinput_rate_meter.sv
// Rate meter for the four fast-input edge counters. Every GATE_CYCLES clocks
// it samples all four counts and presents the per-window edge counts on a
// valid/ready interface, with a sticky overrun flag for lost results.
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : 1 = measure, 0 = stop (return to IDLE)
//   channel0..3         : free-running counts
//   rate_ready          : consumer accepts when rate_valid & rate_ready
//   clr_overrun         : synchronous clear of overrun
//   rate_valid          : rate0..3 / window_id hold an unaccepted result
//   rate0..3            : edges counted in the last completed window
//   window_id           : sequence number of the presented window
//   overrun             : sticky, an unaccepted result was overwritten
module fastinput_rate_meter
    import fastinput_rate_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_CYCLES = 50000000,
    parameter int ID_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] channel0,
    input  logic [CNT_W-1:0] channel1,
    input  logic [CNT_W-1:0] channel2,
    input  logic [CNT_W-1:0] channel3,
    input  logic             rate_ready,
    input  logic             clr_overrun,
    output logic             rate_valid,
    output logic [CNT_W-1:0] rate0,
    output logic [CNT_W-1:0] rate1,
    output logic [CNT_W-1:0] rate2,
    output logic [CNT_W-1:0] rate3,
    output logic [ID_W-1:0]  window_id,
    output logic             overrun
);

    localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [GC_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic              cap_pend_q, cap_pend_d;
    logic              rate_valid_q, rate_valid_d;
    logic [CNT_W-1:0]  rate_q [NUM_CH];
    logic [CNT_W-1:0]  rate_d [NUM_CH];
    logic [ID_W-1:0]   window_id_q, window_id_d;
    logic              overrun_q, overrun_d;

    logic              prime;
    logic              snap;
    logic              load;
    logic              accept;
    logic [CNT_W-1:0]  ch_a    [NUM_CH];
    logic [CNT_W-1:0]  delta_a [NUM_CH];

    assign ch_a[0] = channel0;
    assign ch_a[1] = channel1;
    assign ch_a[2] = channel2;
    assign ch_a[3] = channel3;

    // Gate sequencer. Dropping enable in any state returns to IDLE and
    // suppresses every strobe, which also discards a pending capture.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        cap_pend_d = 1'b0;
        prime      = 1'b0;
        snap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (enable) begin
                    prime      = 1'b1;
                    gate_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (gate_cnt_q == GATE_LAST) begin
                        snap       = 1'b1;
                        gate_cnt_d = '0;
                        cap_pend_d = 1'b1;
                    end else begin
                        gate_cnt_d = gate_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A capture only lands if the meter is still enabled in the capture cycle.
    assign load   = cap_pend_q & enable;
    assign accept = rate_valid_q & rate_ready;

    always_comb begin
        rate_valid_d = rate_valid_q;
        window_id_d  = window_id_q;
        overrun_d    = overrun_q;
        for (int i = 0; i < NUM_CH; i++) begin
            rate_d[i] = rate_q[i];
        end
        if (load) begin
            rate_valid_d = 1'b1;
            window_id_d  = window_id_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                rate_d[i] = delta_a[i];
            end
        end else if (accept) begin
            rate_valid_d = 1'b0;
        end
        // Set has priority over a coincident clear.
        if (load && rate_valid_q && !rate_ready) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gate_cnt_q   <= '0;
            cap_pend_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            window_id_q  <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                rate_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            cap_pend_q   <= cap_pend_d;
            rate_valid_q <= rate_valid_d;
            window_id_q  <= window_id_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                rate_q[i] <= rate_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fastinput_rate_meter_delta_ch #(
            .CNT_W (CNT_W)
        ) u_delta_ch (
            .clk     (clk),
            .rst     (rst),
            .prime   (prime),
            .snap    (snap),
            .cap     (load),
            .channel (ch_a[g]),
            .delta   (delta_a[g])
        );
    end

    assign rate_valid = rate_valid_q;
    assign rate0      = rate_q[0];
    assign rate1      = rate_q[1];
    assign rate2      = rate_q[2];
    assign rate3      = rate_q[3];
    assign window_id  = window_id_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fastinput_rate_meter.sv
// Bench for fastinput_rate_meter with GATE_CYCLES = 10. A window-level
// reference model predicts the outputs and is compared on every falling edge;
// directed scenarios add hand-computed expectations.
module tb_fastinput_rate_meter;

    localparam int G = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] ch [4];
    logic        rate_ready = 1'b0;
    logic        clr_overrun = 1'b0;
    logic        rate_valid;
    logic [31:0] rate0, rate1, rate2, rate3;
    logic [15:0] window_id;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;

    fastinput_rate_meter #(
        .CNT_W       (32),
        .GATE_CYCLES (G),
        .ID_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .channel0    (ch[0]),
        .channel1    (ch[1]),
        .channel2    (ch[2]),
        .channel3    (ch[3]),
        .rate_ready  (rate_ready),
        .clr_overrun (clr_overrun),
        .rate_valid  (rate_valid),
        .rate0       (rate0),
        .rate1       (rate1),
        .rate2       (rate2),
        .rate3       (rate3),
        .window_id   (window_id),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: e counts consecutive enabled edges. The baseline is
    // sampled on enabled edge 2, each window ends G edges later, and its
    // result appears one edge after that.
    int          e = 0;
    logic [31:0] m_base [4];
    logic [31:0] m_pend [4];
    logic [31:0] m_rate [4];
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_id = '0;
    logic        m_load;
    logic        m_acc;

    initial begin
        for (int i = 0; i < 4; i++) begin
            ch[i] = '0; m_base[i] = '0; m_pend[i] = '0; m_rate[i] = '0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e = 0; m_valid = 1'b0; m_ovr = 1'b0; m_id = '0;
            for (int i = 0; i < 4; i++) begin
                m_base[i] = '0; m_pend[i] = '0; m_rate[i] = '0;
            end
        end else begin
            e = enable ? e + 1 : 0;
            m_load = (e >= G + 3) && ((e - 3) % G == 0);
            m_acc  = m_valid && rate_ready;
            if (m_load && m_valid && !rate_ready) m_ovr = 1'b1;
            else if (clr_overrun)                 m_ovr = 1'b0;
            if (m_load) begin
                for (int i = 0; i < 4; i++) m_rate[i] = m_pend[i];
                m_id = m_id + 16'd1;
                m_valid = 1'b1;
            end else if (m_acc) begin
                m_valid = 1'b0;
            end
            if (e == 2) begin
                for (int i = 0; i < 4; i++) m_base[i] = ch[i];
            end else if (e >= G + 2 && (e - 2) % G == 0) begin
                for (int i = 0; i < 4; i++) begin
                    m_pend[i] = ch[i] - m_base[i];
                    m_base[i] = ch[i];
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        vectors++;
        if (rate_valid !== m_valid || overrun !== m_ovr || window_id !== m_id ||
            rate0 !== m_rate[0] || rate1 !== m_rate[1] ||
            rate2 !== m_rate[2] || rate3 !== m_rate[3]) begin
            miscompares++;
            $display("FAIL model t=%0t: got v=%0b ovr=%0b id=%0d r=%0h/%0h/%0h/%0h expected v=%0b ovr=%0b id=%0d r=%0h/%0h/%0h/%0h",
                     $time, rate_valid, overrun, window_id, rate0, rate1, rate2, rate3,
                     m_valid, m_ovr, m_id, m_rate[0], m_rate[1], m_rate[2], m_rate[3]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and move the channel counts.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mode == 0) begin
            ch[0] = ch[0] + 32'd1;
            ch[1] = ch[1] + 32'd2;
            if (cyc % 5 == 0) ch[3] = ch[3] + 32'd1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 99) == 0) ch[i] = $urandom;
                else ch[i] = ch[i] + 32'($urandom_range(0, 40));
            end
        end
    endtask

    task automatic wait_valid(input int bound, input string name, output int n);
        n = 0;
        while (!rate_valid && n < bound) begin
            tick();
            n++;
        end
        if (!rate_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: rate_valid not seen within %0d cycles", name, bound);
        end
    endtask

    int n;
    logic [15:0] id_a;

    initial begin
        repeat (3) tick();
        chk("reset_valid", {31'd0, rate_valid}, 32'd0);
        chk("reset_rate0", rate0, 32'd0);
        chk("reset_id", {16'd0, window_id}, 32'd0);
        chk("reset_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b1;

        // Ramps with ready held high.
        rate_ready = 1'b1;
        enable = 1'b1;
        wait_valid(40, "t1_first", n);
        chk("t1_latency", n, G + 3);
        chk("t1_rate0", rate0, 32'd10);
        chk("t1_rate1", rate1, 32'd20);
        chk("t1_rate2", rate2, 32'd0);
        chk("t1_rate3", rate3, 32'd2);
        chk("t1_id1", {16'd0, window_id}, 32'd1);
        tick();
        chk("t1_pulse", {31'd0, rate_valid}, 32'd0);
        wait_valid(20, "t1_second", n);
        chk("t1_period", n, G - 1);
        chk("t1_id2", {16'd0, window_id}, 32'd2);
        chk("t1_rate1b", rate1, 32'd20);

        // Counter wrap inside a window.
        enable = 1'b0;
        tick(); tick();
        ch[0] = 32'hFFFF_FFFA;
        enable = 1'b1;
        wait_valid(40, "t2", n);
        chk("t2_wrap_rate0", rate0, 32'd10);

        // Two windows without acceptance.
        tick();
        rate_ready = 1'b0;
        id_a = window_id;
        wait_valid(20, "t3_first", n);
        chk("t3_id_first", {16'd0, window_id}, {16'd0, id_a + 16'd1});
        n = 0;
        while (window_id == id_a + 16'd1 && n < 20) begin tick(); n++; end
        chk("t3_id_skip", {16'd0, window_id}, {16'd0, id_a + 16'd2});
        chk("t3_ovr_set", {31'd0, overrun}, 32'd1);
        rate_ready = 1'b1;
        tick();
        chk("t3_accepted", {31'd0, rate_valid}, 32'd0);
        chk("t3_ovr_sticky", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t3_ovr_clr", {31'd0, overrun}, 32'd0);

        // Acceptance coincident with a new load.
        wait_valid(20, "t4_sync", n);
        tick();
        rate_ready = 1'b0;
        wait_valid(20, "t4_first", n);
        id_a = window_id;
        repeat (G - 1) tick();
        chk("t4_held", {31'd0, rate_valid}, 32'd1);
        rate_ready = 1'b1;
        tick();
        chk("t4_valid", {31'd0, rate_valid}, 32'd1);
        chk("t4_id", {16'd0, window_id}, {16'd0, id_a + 16'd1});
        chk("t4_ovr", {31'd0, overrun}, 32'd0);

        // Enable dropped with a result pending.
        tick();
        rate_ready = 1'b0;
        wait_valid(20, "t5_first", n);
        id_a = window_id;
        repeat (3) tick();
        enable = 1'b0;
        repeat (3 * G) tick();
        chk("t5_kept", {31'd0, rate_valid}, 32'd1);
        chk("t5_id", {16'd0, window_id}, {16'd0, id_a});
        rate_ready = 1'b1;
        tick();
        chk("t5_accept", {31'd0, rate_valid}, 32'd0);
        enable = 1'b1;
        wait_valid(40, "t5_reenable", n);
        chk("t5_latency", n, G + 3);
        chk("t5_id_next", {16'd0, window_id}, {16'd0, id_a + 16'd1});

        // Asynchronous reset mid-window with a result presented.
        tick();
        rate_ready = 1'b0;
        wait_valid(20, "t6_first", n);
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        chk("t6_valid0", {31'd0, rate_valid}, 32'd0);
        chk("t6_rate0", rate0, 32'd0);
        chk("t6_rate1", rate1, 32'd0);
        chk("t6_id0", {16'd0, window_id}, 32'd0);
        chk("t6_ovr0", {31'd0, overrun}, 32'd0);
        tick();
        rst = 1'b1;
        rate_ready = 1'b1;
        wait_valid(40, "t6_restart", n);
        chk("t6_latency", n, G + 3);
        chk("t6_id1", {16'd0, window_id}, 32'd1);

        // Randomized traffic, checked by the model every cycle.
        mode = 1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            rate_ready  = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
